// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG bus-access sequencer.
package jtag_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WID_DEF  = 34;
  localparam int unsigned ERR_BIT  = 33;
  localparam int unsigned BUSY_BIT = 32;
  localparam int unsigned INC_DEF  = 4;
  localparam int unsigned TMO_DEF  = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/jtag_mem_ctrl_if.sv
// Single-beat 32-bit bus between the JTAG sequencer (master) and the memory side (slave).
interface jtag_mem_ctrl_if import jtag_pkg::*;;

  logic              BUS_REQ;
  logic              BUS_WE;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_WDATA;
  logic              BUS_ACK;
  logic [DATA_W-1:0] BUS_RDATA;

  modport master (
    output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    input  BUS_ACK, BUS_RDATA
  );

  modport slave (
    input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    output BUS_ACK, BUS_RDATA
  );

endinterface

// File: rtl/jtag_dreg.sv
// Generic TAP data register: parallel capture, LSB-first shift, parallel readout of the low PO_W bits.
module jtag_dreg #(
  parameter int unsigned W    = 34,
  parameter int unsigned PO_W = W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            capture_i,
  input  logic            shift_i,
  input  logic            tdi_i,
  input  logic [W-1:0]    pdata_i,
  output logic [PO_W-1:0] pdata_o,
  output logic            tdo_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (capture_i) begin
      sr_d = pdata_i;
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pdata_o = sr_q[PO_W-1:0];
  assign tdo_o   = sr_q[0];

endmodule

// File: rtl/jtag_mem_ctrl.sv
// Turns JTAG data-register updates into single bus transactions with read prefetch,
// address auto-increment, timeout and overrun reporting.
module jtag_mem_ctrl import jtag_pkg::*; #(
  parameter int unsigned wid = WID_DEF,
  parameter int unsigned TMO = TMO_DEF,
  parameter int unsigned INC = INC_DEF
) (
  input  logic              TCK,
  input  logic              RESET,
  input  logic              SEL,
  input  logic              CAPTURE,
  input  logic              SHIFT,
  input  logic              UPDATE,
  input  logic              TDI,
  output logic              TDO,
  input  logic              AUPD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  jtag_mem_ctrl_if.master   bus,
  output logic              BUSY,
  output logic              ERR
);

  localparam int unsigned CNT_W = (TMO > 1) ? $clog2(TMO + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              dr_upd;
  logic [wid-1:0]    cap_data;
  logic [DATA_W-1:0] sr_data;

  assign dr_upd = SEL & UPDATE;

  // Status word returned to the host on capture.
  always_comb begin
    cap_data                 = '0;
    cap_data[ERR_BIT]        = err_q;
    cap_data[BUSY_BIT]       = (state_q == WAIT);
    cap_data[DATA_W-1:0]     = rdata_q;
  end

  jtag_dreg #(
    .W    (wid),
    .PO_W (DATA_W)
  ) u_dreg (
    .clk_i     (TCK),
    .rst_i     (RESET),
    .capture_i (SEL & CAPTURE),
    .shift_i   (SEL & SHIFT),
    .tdi_i     (TDI),
    .pdata_i   (cap_data),
    .pdata_o   (sr_data),
    .tdo_o     (TDO)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (AUPD) begin
          cur_d  = ADDR;
          mode_d = WR;
          err_d  = 1'b0;
          if (!WR) begin
            state_d = WAIT;
            addr_d  = ADDR;
            we_d    = 1'b0;
            cnt_d   = '0;
          end
        end else if (dr_upd) begin
          state_d = WAIT;
          addr_d  = cur_q;
          we_d    = mode_q;
          cnt_d   = '0;
          if (mode_q) begin
            wdata_d = sr_data;
          end
        end
      end
      WAIT: begin
        // A new request while one is outstanding is dropped and flagged.
        if (AUPD || dr_upd) begin
          err_d = 1'b1;
        end
        if (bus.BUS_ACK) begin
          state_d = IDLE;
          cur_d   = cur_q + ADDR_W'(INC);
          if (!we_q) begin
            rdata_d = bus.BUS_RDATA;
          end
        end else if (cnt_q == CNT_W'(TMO - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      mode_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.BUS_REQ   = (state_q == WAIT);
  assign bus.BUS_WE    = we_q;
  assign bus.BUS_ADDR  = addr_q;
  assign bus.BUS_WDATA = wdata_q;
  assign BUSY          = (state_q == WAIT);
  assign ERR           = err_q;

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Scoreboard bench for jtag_mem_ctrl: expected bus transactions are queued at stimulus time
// and matched when BUS_REQ rises; scans check the captured status word.
module tb_jtag_mem_ctrl;
  import jtag_pkg::*;

  logic        TCK = 1'b0;
  logic        RESET = 1'b1;
  logic        SEL = 1'b0, CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0, TDI = 1'b0;
  logic        AUPD = 1'b0, WR = 1'b0;
  logic [31:0] ADDR = '0;
  logic        TDO, BUSY, ERR;

  jtag_mem_ctrl_if bif();

  jtag_mem_ctrl dut (
    .TCK     (TCK),
    .RESET   (RESET),
    .SEL     (SEL),
    .CAPTURE (CAPTURE),
    .SHIFT   (SHIFT),
    .UPDATE  (UPDATE),
    .TDI     (TDI),
    .TDO     (TDO),
    .AUPD    (AUPD),
    .WR      (WR),
    .ADDR    (ADDR),
    .bus     (bif),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  always #5 TCK = ~TCK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Bus responder controls (written by the main sequence only)
  bit          ack_en    = 1'b1;
  int          ack_dly   = 0;
  logic [31:0] rd_val    = '0;
  bit          stray_ack = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: ACK after ack_dly waiting cycles, plus an optional stray ACK.
  int wcnt = 0;
  initial begin
    bif.BUS_ACK   = 1'b0;
    bif.BUS_RDATA = '0;
    forever begin
      @(negedge TCK);
      bif.BUS_ACK = 1'b0;
      if (bif.BUS_REQ && ack_en) begin
        if (wcnt == ack_dly) begin
          bif.BUS_ACK   = 1'b1;
          bif.BUS_RDATA = rd_val;
          wcnt          = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (stray_ack) begin
        bif.BUS_ACK   = 1'b1;
        bif.BUS_RDATA = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: match each new request against the scoreboard, and check address hold.
  logic        req_prev = 1'b0;
  logic [31:0] lat_addr = '0;
  initial begin
    txn_t t;
    forever begin
      @(negedge TCK);
      if (bif.BUS_REQ && !req_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", 64'(bif.BUS_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          t = sb.pop_front();
          chk("bus_we",   64'(bif.BUS_WE),   64'(t.we));
          chk("bus_addr", 64'(bif.BUS_ADDR), 64'(t.addr));
          if (t.we) chk("bus_wdata", 64'(bif.BUS_WDATA), 64'(t.wdata));
        end
        lat_addr = bif.BUS_ADDR;
      end else if (bif.BUS_REQ) begin
        chk("addr_hold", 64'(bif.BUS_ADDR), 64'(lat_addr));
      end
      req_prev = bif.BUS_REQ;
    end
  end

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    sb.push_back(t);
  endtask

  task automatic aupd(input logic wr, input logic [31:0] a);
    AUPD = 1'b1; WR = wr; ADDR = a;
    @(negedge TCK);
    AUPD = 1'b0;
  endtask

  task automatic upd_pulse();
    SEL = 1'b1; UPDATE = 1'b1;
    @(negedge TCK);
    UPDATE = 1'b0; SEL = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (BUSY && n < 2000) begin
      n++;
      @(negedge TCK);
    end
    if (BUSY) chk("wait_idle_bound", 64'(BUSY), 64'd0);
  endtask

  task automatic dr_scan(input logic [33:0] din, input bit do_upd, output logic [33:0] dout);
    SEL = 1'b1; CAPTURE = 1'b1;
    @(negedge TCK);
    CAPTURE = 1'b0; SHIFT = 1'b1;
    for (int i = 0; i < 34; i++) begin
      dout[i] = TDO;
      TDI     = din[i];
      @(negedge TCK);
    end
    SHIFT = 1'b0; UPDATE = do_upd;
    @(negedge TCK);
    UPDATE = 1'b0; SEL = 1'b0;
  endtask

  initial begin
    int          n;
    logic [33:0] so;
    logic [31:0] wd [3];
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;

    repeat (3) @(negedge TCK);
    RESET = 1'b0;
    chk("rst_req",  64'(bif.BUS_REQ), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_err",  64'(ERR), 64'd0);
    chk("rst_tdo",  64'(TDO), 64'd0);
    chk("rst_addr", 64'(bif.BUS_ADDR), 64'd0);

    // Read with prefetch
    ack_en = 1'b1; ack_dly = 2; rd_val = 32'hDEAD_BEEF;
    push_txn(1'b0, 32'h1000, '0);
    aupd(1'b0, 32'h1000);
    wait_idle(n);
    chk("rd_len", 64'(n), 64'd3);
    rd_val = 32'hCAFE_F00D;
    push_txn(1'b0, 32'h1004, '0);
    dr_scan('0, 1'b1, so);
    chk("rd_scan", 64'(so), 64'h0_DEAD_BEEF);
    wait_idle(n);
    dr_scan('0, 1'b0, so);
    chk("prefetch_scan", 64'(so), 64'h0_CAFE_F00D);

    // Burst write: no bus activity at the address update itself
    ack_dly = 1;
    aupd(1'b1, 32'h2000);
    repeat (3) @(negedge TCK);
    chk("wr_aupd_idle", 64'(bif.BUS_REQ), 64'd0);
    for (int k = 0; k < 3; k++) begin
      push_txn(1'b1, 32'h2000 + 32'(4 * k), wd[k]);
      dr_scan({2'b00, wd[k]}, 1'b1, so);
      if (k == 0) chk("wr_first_scan", 64'(so), 64'h0_CAFE_F00D);
      wait_idle(n);
    end
    chk("wr_err", 64'(ERR), 64'd0);

    // Timeout
    ack_en = 1'b0;
    push_txn(1'b0, 32'h3000, '0);
    aupd(1'b0, 32'h3000);
    wait_idle(n);
    chk("tmo_len", 64'(n), 64'd255);
    chk("tmo_err", 64'(ERR), 64'd1);
    ack_en = 1'b1; ack_dly = 0; rd_val = 32'h3333_0000;
    push_txn(1'b0, 32'h3000, '0);
    dr_scan('0, 1'b1, so);
    chk("tmo_scan", 64'(so), 64'h2_CAFE_F00D);
    wait_idle(n);
    chk("err_sticky", 64'(ERR), 64'd1);
    rd_val = 32'h4444_0000;
    push_txn(1'b0, 32'h4000, '0);
    aupd(1'b0, 32'h4000);
    chk("err_clr", 64'(ERR), 64'd0);
    wait_idle(n);

    // Overrun
    ack_dly = 10; rd_val = 32'h5555_0000;
    push_txn(1'b0, 32'h5000, '0);
    aupd(1'b0, 32'h5000);
    upd_pulse();
    chk("ovr_err", 64'(ERR), 64'd1);
    wait_idle(n);
    chk("ovr_len", 64'(n), 64'd10);
    chk("ovr_sb", 64'(sb.size()), 64'd0);
    dr_scan('0, 1'b0, so);
    chk("ovr_scan", 64'(so), 64'h2_5555_0000);

    // Address wrap
    ack_dly = 0; rd_val = 32'h0BAD_CAFE;
    push_txn(1'b0, 32'hFFFF_FFFC, '0);
    aupd(1'b0, 32'hFFFF_FFFC);
    wait_idle(n);
    rd_val = 32'h1234_5678;
    push_txn(1'b0, 32'h0000_0000, '0);
    upd_pulse();
    wait_idle(n);
    dr_scan('0, 1'b0, so);
    chk("wrap_scan", 64'(so), 64'h0_1234_5678);

    // ACK on the timeout cycle wins
    ack_dly = 254; rd_val = 32'h600D_D00D;
    push_txn(1'b0, 32'h6000, '0);
    aupd(1'b0, 32'h6000);
    wait_idle(n);
    chk("race_len", 64'(n), 64'd255);
    chk("race_err", 64'(ERR), 64'd0);
    dr_scan('0, 1'b0, so);
    chk("race_scan", 64'(so), 64'h0_600D_D00D);

    // Reset in the middle of a transaction, then a late ACK
    ack_en = 1'b0;
    push_txn(1'b0, 32'h7000, '0);
    aupd(1'b0, 32'h7000);
    repeat (4) @(negedge TCK);
    chk("pre_rst_req", 64'(bif.BUS_REQ), 64'd1);
    RESET = 1'b1;
    @(negedge TCK);
    RESET = 1'b0;
    chk("mid_rst_req",   64'(bif.BUS_REQ), 64'd0);
    chk("mid_rst_busy",  64'(BUSY), 64'd0);
    chk("mid_rst_err",   64'(ERR), 64'd0);
    chk("mid_rst_we",    64'(bif.BUS_WE), 64'd0);
    chk("mid_rst_addr",  64'(bif.BUS_ADDR), 64'd0);
    chk("mid_rst_wdata", 64'(bif.BUS_WDATA), 64'd0);
    chk("mid_rst_tdo",   64'(TDO), 64'd0);
    stray_ack = 1'b1;
    @(negedge TCK);
    stray_ack = 1'b0;
    repeat (3) @(negedge TCK);
    chk("late_ack_req", 64'(bif.BUS_REQ), 64'd0);
    dr_scan('0, 1'b0, so);
    chk("late_ack_scan", 64'(so), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_mem_ctrl.md
# jtag_mem_ctrl

Bus-access sequencer behind the JTAG user chains. Takes the latched write flag and start address from the JTAG address register, plus a 34-bit data chain of its own, and turns each data-register update into a single 32-bit bus transaction. Reads prefetch, and the address auto-increments on every completed access. It runs entirely in the TCK domain and provides timeout and overrun error reporting back through the data chain.

## Interface

Parameters:
- `wid`, default 34: data-chain length, laid out as {ERR, BUSY, DATA[31:0]}.
- `TMO`, default 255: bus cycles to wait for `BUS_ACK` before aborting.
- `INC`, default 4: address increment after each successful access.

Ports:
- `TCK` in 1: the only clock. All logic updates on posedge.
- `RESET` in 1: synchronous, active-high reset.
- `SEL` in 1: the data chain is selected in the TAP.
- `CAPTURE`, `SHIFT`, `UPDATE` in 1 each: TAP state strobes for the data chain, qualified by `SEL`.
- `TDI` in 1: serial in.
- `TDO` out 1: serial out, equal to `SR[0]`.
- `AUPD` in 1: one-cycle strobe marking an update of the address chain.
- `WR` in 1: access direction from the address register (1 = write).
- `ADDR` in 32: start address from the address register.
- `BUS_REQ` out 1: transaction request.
- `BUS_WE` out 1: write enable, valid while `BUS_REQ` is high.
- `BUS_ADDR` out 32: transaction address.
- `BUS_WDATA` out 32: write data.
- `BUS_ACK` in 1: one-cycle completion from the bus.
- `BUS_RDATA` in 32: read data, valid with `BUS_ACK`.
- `BUSY` out 1: a transaction is outstanding.
- `ERR` out 1: sticky error flag.

## Operation

Reset values:
- `SR`, `CUR` (current address), `RDATA`, `BUS_*`, `BUSY`, `ERR`, timeout counter: all 0.
- FSM: IDLE.

Registered state:
- `CUR`, `MODE` (latched `WR`), `RDATA`.

FSM has two states, IDLE and WAIT:
- **Launch, IDLE -> WAIT:**
  - Sets `BUS_REQ=1`, `BUS_ADDR=CUR`, `BUS_WE=MODE`, `BUSY=1`, counter=0.
- **`AUPD` in IDLE:**
  - `CUR<=ADDR`, `MODE<=WR`, `ERR<=0`.
  - If `WR=0`, launch a read at `ADDR` in the same edge.
  - If `WR=1`, no bus activity.
- **`SEL&UPDATE` in IDLE:**
  - `MODE=1`: launch a write with `BUS_WDATA<=SR[31:0]`.
  - `MODE=0`: launch a read at `CUR` (next-word prefetch).
- **WAIT + `BUS_ACK`:**
  - `BUS_REQ<=0`, `BUSY<=0`, `CUR<=CUR+INC`, return to IDLE.
  - On a read, `RDATA<=BUS_RDATA`.
- **WAIT, counter reaches `TMO` without ACK:**
  - `BUS_REQ<=0`, `BUSY<=0`, `ERR<=1`.
  - `CUR` and `RDATA` unchanged; return to IDLE.
  - If ACK arrives on that same edge, the ACK wins and no error is raised.
- **`AUPD` or `SEL&UPDATE` while in WAIT (overrun):**
  - Request is ignored, `ERR<=1`, and `CUR`/`MODE` are not loaded.
- **Data chain:**
  - `SEL&CAPTURE`: `SR<={ERR,BUSY,RDATA}`.
  - `SEL&SHIFT`: `SR<={TDI,SR[wid-1:1]}`.
  - `UPDATE` uses the `SR` value before that edge.
  - Strobes are mutually exclusive by TAP construction.
  - Capture during WAIT returns the stale `RDATA` with `BUSY=1`; the host retries.
- **Address arithmetic:** `CUR+INC` is modulo 2^32; `0xFFFFFFFC+4` wraps to 0.
- **`RESET` mid-transaction:** `BUS_REQ` is low after that edge. A late `BUS_ACK` arriving in IDLE is ignored.

## Timing

- Launch edge N: `BUS_REQ`, `BUS_ADDR`, `BUS_WE`, `BUS_WDATA` and `BUSY` are all valid after edge N.
- ACK sampled at edge M: `BUS_REQ` and `BUSY` are low after M. `RDATA` and `CUR` are updated at M.
- Earliest next launch is edge M+1.
- Minimum access is 1 cycle of `BUS_REQ` when ACK is returned in the first cycle.
- Timeout: with no ACK, `BUS_REQ` drops after edge N+TMO.
- `BUS_*` outputs hold steady while `BUS_REQ=1`.

## Structure

- Package `jtag_pkg` holds:
  - FSM state enum (IDLE, WAIT).
  - Status bit positions `ERR_BIT=33`, `BUSY_BIT=32`.
  - Defaults for `INC` and `TMO`.
- Sub-module `jtag_dreg`: the generic capture/shift/update shift register (width parameter, `TDO`, parallel in/out), instantiated at `wid`.
- FSM, counter and address logic live in the top module.

## Test plan

- **Read with prefetch:**
  - `AUPD`, `WR=0`, `ADDR=0x1000`, ACK after 3 cycles with `RDATA=0xDEADBEEF` -> `BUS_ADDR=0x1000`, `BUS_WE=0`.
  - A subsequent capture+shift yields `TDO` LSB-first of {0,0,0xDEADBEEF}.
  - `CUR=0x1004`.
- **Burst write:**
  - `AUPD`, `WR=1`, `ADDR=0x2000`, then three DR scans `0x11111111`, `0x22222222`, `0x33333333`.
  - Expect writes at 0x2000, 0x2004, 0x2008 with matching `BUS_WDATA`.
  - No bus activity at `AUPD` itself.
- **Timeout:**
  - Read launched, `BUS_ACK` never asserted -> `BUS_REQ` drops after 255 cycles, `ERR=1`, `CUR` unchanged.
  - Next `AUPD` clears `ERR`.
- **Overrun:**
  - `SEL&UPDATE` while `BUSY` -> no second request, `ERR=1`.
  - Original transaction completes normally.
- **Wrap and ACK/timeout race:**
  - `ADDR=0xFFFFFFFC` read ack'd -> `CUR=0`.
  - ACK on exactly cycle `TMO` -> `ERR=0`, data latched.
- **Reset mid-WAIT:**
  - `RESET` while `BUS_REQ=1` -> all outputs 0 after the edge.
  - A late ACK is ignored and `RDATA` stays 0.
